// File: rtl/ram_dma_ci_burst.sv
// Custom-instruction DMA engine: moves blocks between a dual-port scratch RAM and the
// shared bus in automatically sized bursts, with byte swapping in both directions.
module ram_dma_ci_burst #(
  parameter logic [7:0] customId       = 8'h00,
  parameter int         MEM_ADDR_WIDTH = 9,
  parameter int         BLOCK_WIDTH    = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  input  logic [7:0]  ciN,
  output logic        done,
  output logic [31:0] result,
  output logic        requestTransaction,
  input  logic        transactionGranted,
  input  logic [31:0] addressDataIn,
  input  logic        endTransactionIn,
  input  logic        dataValidIn,
  input  logic        busErrorIn,
  input  logic        busy,
  output logic [31:0] addressDataOut,
  output logic [3:0]  byteEnablesOut,
  output logic [7:0]  burstSizeOut,
  output logic        readNotWriteOut,
  output logic        beginTransactionOut,
  output logic        endTransactionOut,
  output logic        dataValidOut
);
  localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

  // Bus handshake: requestTransaction holds until transactionGranted; read beats move on
  // dataValidIn; write beats move when dataValidOut=1 and busy=0 (data held while busy).
  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_REQ, S_BEGIN, S_XFER, S_NEXT, S_ERRWAIT
  } state_t;

  state_t state, state_nx;

  function automatic logic [31:0] swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  logic                      ci_sel, ci_wr, ci_mem_we;
  logic [2:0]                ci_idx;
  logic [MEM_ADDR_WIDTH-1:0] ci_addr;

  logic [31:0]               bus_addr_r;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_r;
  logic [BLOCK_WIDTH-1:0]    block_r;
  logic [7:0]                burst_r;
  logic [1:0]                ctrl_r;
  logic                      err_r, cmpl_r, dir_read;

  logic [31:0]               cur_bus;
  logic [MEM_ADDR_WIDTH-1:0] cur_mem, cur_mem_nx;
  logic [BLOCK_WIDTH-1:0]    remaining;
  logic [8:0]                beat_cnt, burst_beats, beats_w;
  logic [7:0]                burst_size_w;
  logic                      start_ok, beat_ev, dma_we, stat_busy;

  logic                      rd_pend, done_r;
  logic [2:0]                rd_idx;
  logic [31:0]               result_r, rd_mux, ci_rdata, dma_rdata;

  logic [31:0]               mem [DEPTH];

  assign ci_sel    = start && (ciN == customId) && (valueA[31:13] == '0);
  assign ci_idx    = valueA[12:10];
  assign ci_wr     = valueA[9];
  assign ci_addr   = valueA[MEM_ADDR_WIDTH-1:0];
  assign ci_mem_we = ci_sel && ci_wr && (ci_idx == 3'd0);

  assign stat_busy = (state != S_IDLE);
  assign start_ok  = (state == S_IDLE) && ((ctrl_r == 2'd1) || (ctrl_r == 2'd2));

  // A burst never exceeds 256 beats, so the min() fits in the 9-bit beat counter.
  assign burst_beats  = {1'b0, burst_r} + 9'd1;
  assign beats_w      = (32'(remaining) < 32'(burst_beats)) ? 9'(remaining) : burst_beats;
  assign burst_size_w = 8'(beats_w - 9'd1);

  assign beat_ev = (state == S_XFER) && !busErrorIn &&
                   (dir_read ? dataValidIn : ((beat_cnt != 9'd0) && !busy));
  assign dma_we  = beat_ev && dir_read;
  // RAM read address tracks the post-beat pointer so write data is prefetched one cycle early.
  assign cur_mem_nx = beat_ev ? cur_mem + MEM_ADDR_WIDTH'(1) : cur_mem;

  // Scratch RAM; the DMA write is last so it wins a same-address collision with the CI.
  always_ff @(posedge clock) begin
    if (ci_mem_we) mem[ci_addr] <= valueB;
    if (dma_we)    mem[cur_mem] <= swap32(addressDataIn);
    ci_rdata  <= mem[ci_addr];
    dma_rdata <= mem[cur_mem_nx];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus_addr_r <= '0;
      mem_addr_r <= '0;
      block_r    <= '0;
      burst_r    <= '0;
      ctrl_r     <= '0;
    end else begin
      ctrl_r <= 2'd0;
      if (ci_sel && ci_wr) begin
        case (ci_idx)
          3'd1: bus_addr_r <= valueB;
          3'd2: mem_addr_r <= valueB[MEM_ADDR_WIDTH-1:0];
          3'd3: block_r    <= valueB[BLOCK_WIDTH-1:0];
          3'd4: burst_r    <= valueB[7:0];
          3'd5: if ((valueB == 32'd1) || (valueB == 32'd2)) ctrl_r <= valueB[1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    case (rd_idx)
      3'd0:    rd_mux = ci_rdata;
      3'd1:    rd_mux = bus_addr_r;
      3'd2:    rd_mux = 32'(mem_addr_r);
      3'd3:    rd_mux = 32'(block_r);
      3'd4:    rd_mux = 32'(burst_r);
      3'd5:    rd_mux = {29'd0, cmpl_r, err_r, stat_busy};
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_pend  <= 1'b0;
      rd_idx   <= '0;
      done_r   <= 1'b0;
      result_r <= '0;
    end else begin
      rd_pend  <= ci_sel && !ci_wr;
      rd_idx   <= ci_idx;
      done_r   <= (ci_sel && ci_wr) || rd_pend;
      result_r <= rd_pend ? rd_mux : 32'd0;
    end
  end

  assign done   = done_r;
  assign result = result_r;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_ok) state_nx = S_INIT;
      S_INIT:  state_nx = (block_r == '0) ? S_IDLE : S_REQ;
      S_REQ:   if (transactionGranted) state_nx = S_BEGIN;
      S_BEGIN: state_nx = S_XFER;
      S_XFER: begin
        if (busErrorIn)    state_nx = endTransactionIn ? S_IDLE : S_ERRWAIT;
        else if (dir_read) begin
          if (endTransactionIn) state_nx = S_NEXT;
        end else if (beat_cnt == 9'd0) state_nx = S_NEXT;
      end
      S_NEXT:    state_nx = (remaining != '0) ? S_REQ : S_IDLE;
      S_ERRWAIT: if (endTransactionIn) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    requestTransaction  = 1'b0;
    beginTransactionOut = 1'b0;
    addressDataOut      = 32'd0;
    byteEnablesOut      = 4'd0;
    burstSizeOut        = 8'd0;
    readNotWriteOut     = 1'b0;
    dataValidOut        = 1'b0;
    endTransactionOut   = 1'b0;
    case (state)
      S_REQ: requestTransaction = 1'b1;
      S_BEGIN: begin
        beginTransactionOut = 1'b1;
        addressDataOut      = cur_bus;
        byteEnablesOut      = 4'hF;
        burstSizeOut        = burst_size_w;
        readNotWriteOut     = dir_read;
      end
      S_XFER: begin
        if (!dir_read && !busErrorIn) begin
          if (beat_cnt != 9'd0) begin
            dataValidOut   = 1'b1;
            addressDataOut = swap32(dma_rdata);
          end else begin
            endTransactionOut = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dir_read  <= 1'b0;
      err_r     <= 1'b0;
      cmpl_r    <= 1'b0;
      cur_bus   <= '0;
      cur_mem   <= '0;
      remaining <= '0;
      beat_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start_ok) begin
          dir_read <= (ctrl_r == 2'd1);
          err_r    <= 1'b0;
          cmpl_r   <= 1'b0;
        end
        S_INIT: begin
          cur_bus   <= bus_addr_r;
          cur_mem   <= mem_addr_r;
          remaining <= block_r;
          if (block_r == '0) cmpl_r <= 1'b1;
        end
        S_BEGIN: beat_cnt <= beats_w;
        S_XFER: begin
          if (busErrorIn) err_r <= 1'b1;
          else if (beat_ev) begin
            cur_mem   <= cur_mem_nx;
            cur_bus   <= cur_bus + 32'd4;
            remaining <= remaining - BLOCK_WIDTH'(1);
            beat_cnt  <= beat_cnt - 9'd1;
          end
        end
        S_NEXT: if (remaining == '0) cmpl_r <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_dma_ci_burst.sv
// Directed bench for ram_dma_ci_burst: CI register/memory table plus hand-written
// read, write, error, empty-block, busy-start and mid-burst reset sequences.
module tb_ram_dma_ci_burst;
  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] valueA, valueB;
  logic [7:0]  ciN;
  logic        done;
  logic [31:0] result;
  logic        requestTransaction, transactionGranted;
  logic [31:0] addressDataIn;
  logic        endTransactionIn, dataValidIn, busErrorIn, busy;
  logic [31:0] addressDataOut;
  logic [3:0]  byteEnablesOut;
  logic [7:0]  burstSizeOut;
  logic        readNotWriteOut, beginTransactionOut, endTransactionOut, dataValidOut;

  int total = 0;
  int bad   = 0;
  int beat_idx;

  ram_dma_ci_burst dut (
    .clock(clock), .reset(reset), .start(start), .valueA(valueA), .valueB(valueB),
    .ciN(ciN), .done(done), .result(result),
    .requestTransaction(requestTransaction), .transactionGranted(transactionGranted),
    .addressDataIn(addressDataIn), .endTransactionIn(endTransactionIn),
    .dataValidIn(dataValidIn), .busErrorIn(busErrorIn), .busy(busy),
    .addressDataOut(addressDataOut), .byteEnablesOut(byteEnablesOut),
    .burstSizeOut(burstSizeOut), .readNotWriteOut(readNotWriteOut),
    .beginTransactionOut(beginTransactionOut), .endTransactionOut(endTransactionOut),
    .dataValidOut(dataValidOut)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  sel;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t vecs [8];

  function automatic logic [31:0] swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [31:0] mk_a(input logic [2:0] sel, input logic wr, input logic [8:0] addr);
    return {19'd0, sel, wr, addr};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic ci_write(input logic [2:0] sel, input logic [8:0] addr, input logic [31:0] data);
    start = 1'b1; ciN = 8'h00; valueA = mk_a(sel, 1'b1, addr); valueB = data;
    tick();
    start = 1'b0; valueA = '0; valueB = '0;
    chk("ci_wr_done", {31'd0, done}, 32'd1);
    chk("ci_wr_result", result, 32'd0);
  endtask

  task automatic ci_read(input logic [2:0] sel, input logic [8:0] addr, output logic [31:0] data);
    start = 1'b1; ciN = 8'h00; valueA = mk_a(sel, 1'b0, addr); valueB = '0;
    tick();
    start = 1'b0; valueA = '0;
    chk("ci_rd_done_n1", {31'd0, done}, 32'd0);
    tick();
    chk("ci_rd_done_n2", {31'd0, done}, 32'd1);
    data = result;
    tick();
    chk("ci_rd_result_after", result, 32'd0);
  endtask

  task automatic wait_req(input string name);
    for (int k = 0; k < 40 && requestTransaction !== 1'b1; k++) tick();
    chk(name, {31'd0, requestTransaction}, 32'd1);
  endtask

  task automatic grant_and_check_begin(input logic [31:0] addr, input logic [7:0] bs, input logic rnw);
    transactionGranted = 1'b1;
    tick();
    transactionGranted = 1'b0;
    chk("begin_pulse", {31'd0, beginTransactionOut}, 32'd1);
    chk("begin_addr", addressDataOut, addr);
    chk("begin_bs", {24'd0, burstSizeOut}, {24'd0, bs});
    chk("begin_rnw", {31'd0, readNotWriteOut}, {31'd0, rnw});
    chk("begin_be", {28'd0, byteEnablesOut}, 32'hF);
    tick();
  endtask

  task automatic serve_read_burst(input logic [31:0] addr, input logic [7:0] bs, input int nbeats);
    wait_req("rd_req");
    grant_and_check_begin(addr, bs, 1'b1);
    for (int i = 0; i < nbeats; i++) begin
      dataValidIn      = 1'b1;
      addressDataIn    = 32'h11223344 + beat_idx;
      endTransactionIn = (i == nbeats - 1);
      tick();
      beat_idx++;
    end
    dataValidIn = 1'b0; endTransactionIn = 1'b0; addressDataIn = '0;
  endtask

  logic [31:0] rd;
  logic [31:0] wdat [4];
  int          acc;
  logic        saw_end, any_req;

  initial begin
    reset = 1'b0; start = 1'b0; valueA = '0; valueB = '0; ciN = '0;
    transactionGranted = 1'b0; addressDataIn = '0; endTransactionIn = 1'b0;
    dataValidIn = 1'b0; busErrorIn = 1'b0; busy = 1'b0;
    wdat[0] = 32'hA1A2A3A4; wdat[1] = 32'hB1B2B3B4; wdat[2] = 32'hC1C2C3C4; wdat[3] = 32'hD1D2D3D4;

    vecs[0] = '{sel: 3'd0, addr: 9'd5,     wdata: 32'hDEADBEEF, exp: 32'hDEADBEEF};
    vecs[1] = '{sel: 3'd0, addr: 9'h1FF,   wdata: 32'hCAFEF00D, exp: 32'hCAFEF00D};
    vecs[2] = '{sel: 3'd1, addr: 9'd0,     wdata: 32'h12345678, exp: 32'h12345678};
    vecs[3] = '{sel: 3'd2, addr: 9'd0,     wdata: 32'hFFFFFFFF, exp: 32'h000001FF};
    vecs[4] = '{sel: 3'd3, addr: 9'd0,     wdata: 32'hFFFFFFFF, exp: 32'h000003FF};
    vecs[5] = '{sel: 3'd4, addr: 9'd0,     wdata: 32'h000001AB, exp: 32'h000000AB};
    vecs[6] = '{sel: 3'd6, addr: 9'd0,     wdata: 32'h00005555, exp: 32'h00000000};
    vecs[7] = '{sel: 3'd7, addr: 9'd0,     wdata: 32'h00005555, exp: 32'h00000000};

    // Reset state
    tick(); tick();
    chk("reset_outputs_zero", {31'd0, |{done, result, requestTransaction, addressDataOut, byteEnablesOut,
        burstSizeOut, readNotWriteOut, beginTransactionOut, endTransactionOut, dataValidOut}}, 32'd0);
    reset = 1'b1;
    tick();
    ci_read(3'd5, 9'd0, rd);
    chk("reset_status", rd, 32'd0);

    // CI register / memory table
    for (int i = 0; i < 8; i++) begin
      ci_write(vecs[i].sel, vecs[i].addr, vecs[i].wdata);
      ci_read(vecs[i].sel, vecs[i].addr, rd);
      chk($sformatf("table_%0d", i), rd, vecs[i].exp);
    end

    // Foreign CI number and non-zero upper operand bits are not selected
    start = 1'b1; ciN = 8'h01; valueA = mk_a(3'd0, 1'b1, 9'd5); valueB = 32'h0BADF00D;
    tick();
    ciN = 8'h00; valueA = mk_a(3'd0, 1'b1, 9'd5) | 32'h0001_0000;
    chk("foreign_ci_no_done", {31'd0, done}, 32'd0);
    tick();
    start = 1'b0; valueA = '0; valueB = '0;
    chk("bad_opnd_no_done", {31'd0, done}, 32'd0);
    ci_read(3'd0, 9'd5, rd);
    chk("foreign_ci_no_write", rd, 32'hDEADBEEF);

    // Read transfer: 10 words in bursts of 4, 4, 2
    ci_write(3'd1, 9'd0, 32'h100);
    ci_write(3'd2, 9'd0, 32'd0);
    ci_write(3'd3, 9'd0, 32'd10);
    ci_write(3'd4, 9'd0, 32'd3);
    ci_write(3'd5, 9'd0, 32'd1);
    beat_idx = 0;
    serve_read_burst(32'h100, 8'd3, 4);
    serve_read_burst(32'h110, 8'd3, 4);
    serve_read_burst(32'h120, 8'd1, 2);
    tick();
    ci_read(3'd5, 9'd0, rd);
    chk("rd_status", rd, 32'b100);
    ci_read(3'd0, 9'd0, rd);
    chk("rd_mem0", rd, 32'h44332211);
    ci_read(3'd0, 9'd9, rd);
    chk("rd_mem9", rd, swap32(32'h11223344 + 9));

    // Write transfer wrapping 0x1FE..0x001 with a two-cycle stall
    ci_write(3'd0, 9'h1FE, wdat[0]);
    ci_write(3'd0, 9'h1FF, wdat[1]);
    ci_write(3'd0, 9'h000, wdat[2]);
    ci_write(3'd0, 9'h001, wdat[3]);
    ci_write(3'd1, 9'd0, 32'h200);
    ci_write(3'd2, 9'd0, 32'h1FE);
    ci_write(3'd3, 9'd0, 32'd4);
    ci_write(3'd4, 9'd0, 32'd7);
    ci_write(3'd5, 9'd0, 32'd2);
    wait_req("wr_req");
    grant_and_check_begin(32'h200, 8'd3, 1'b0);
    acc = 0; saw_end = 1'b0;
    for (int c = 0; c < 20 && !saw_end; c++) begin
      busy = (c == 1 || c == 2);
      if (acc < 4) begin
        chk("wr_valid", {31'd0, dataValidOut}, 32'd1);
        chk("wr_data", addressDataOut, swap32(wdat[acc]));
        chk("wr_no_end", {31'd0, endTransactionOut}, 32'd0);
        if (!busy) acc++;
      end else begin
        chk("wr_valid_low_at_end", {31'd0, dataValidOut}, 32'd0);
        chk("wr_end_pulse", {31'd0, endTransactionOut}, 32'd1);
        saw_end = 1'b1;
      end
      tick();
    end
    busy = 1'b0;
    chk("wr_end_seen", {31'd0, saw_end}, 32'd1);
    chk("wr_end_one_cycle", {31'd0, endTransactionOut}, 32'd0);
    tick();
    ci_read(3'd5, 9'd0, rd);
    chk("wr_status", rd, 32'b100);

    // Bus error on beat 2 without end: wait in ERRWAIT
    ci_write(3'd1, 9'd0, 32'h300);
    ci_write(3'd2, 9'd0, 32'h40);
    ci_write(3'd3, 9'd0, 32'd8);
    ci_write(3'd4, 9'd0, 32'd3);
    ci_write(3'd5, 9'd0, 32'd1);
    wait_req("err_req");
    grant_and_check_begin(32'h300, 8'd3, 1'b1);
    dataValidIn = 1'b1; addressDataIn = 32'h0A0B0C0D;
    tick();
    dataValidIn = 1'b0; busErrorIn = 1'b1; addressDataIn = '0;
    tick();
    busErrorIn = 1'b0;
    chk("errwait_no_req", {31'd0, requestTransaction | beginTransactionOut}, 32'd0);
    ci_read(3'd5, 9'd0, rd);
    chk("errwait_status", rd, 32'b011);
    endTransactionIn = 1'b1;
    tick();
    endTransactionIn = 1'b0;
    ci_read(3'd5, 9'd0, rd);
    chk("err_status", rd, 32'b010);
    ci_read(3'd0, 9'h40, rd);
    chk("err_first_beat_stored", rd, 32'h0D0C0B0A);

    // Block size 0: no bus request, complete only; clears the sticky error
    ci_write(3'd3, 9'd0, 32'd0);
    ci_write(3'd5, 9'd0, 32'd1);
    any_req = 1'b0;
    for (int c = 0; c < 8; c++) begin
      any_req = any_req | requestTransaction;
      tick();
    end
    chk("blk0_no_req", {31'd0, any_req}, 32'd0);
    ci_read(3'd5, 9'd0, rd);
    chk("blk0_status", rd, 32'b100);

    // Start while busy is ignored
    ci_write(3'd1, 9'd0, 32'h400);
    ci_write(3'd2, 9'd0, 32'h80);
    ci_write(3'd3, 9'd0, 32'd2);
    ci_write(3'd4, 9'd0, 32'd3);
    ci_write(3'd5, 9'd0, 32'd1);
    wait_req("busy_req");
    ci_write(3'd5, 9'd0, 32'd2);
    ci_read(3'd5, 9'd0, rd);
    chk("busy_status", rd, 32'b001);
    beat_idx = 20;
    serve_read_burst(32'h400, 8'd1, 2);
    any_req = 1'b0;
    for (int c = 0; c < 10; c++) begin
      any_req = any_req | requestTransaction;
      tick();
    end
    chk("busy_start_ignored", {31'd0, any_req}, 32'd0);
    ci_read(3'd0, 9'h81, rd);
    chk("busy_mem81", rd, swap32(32'h11223344 + 21));

    // Reset in the middle of a write burst
    ci_write(3'd1, 9'd0, 32'h500);
    ci_write(3'd2, 9'd0, 32'h1FE);
    ci_write(3'd3, 9'd0, 32'd4);
    ci_write(3'd4, 9'd0, 32'd7);
    ci_write(3'd5, 9'd0, 32'd2);
    wait_req("rst_req");
    grant_and_check_begin(32'h500, 8'd3, 1'b0);
    tick();
    chk("rst_pre_valid", {31'd0, dataValidOut}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_mid_outputs_zero", {31'd0, |{done, result, requestTransaction, addressDataOut, byteEnablesOut,
        burstSizeOut, readNotWriteOut, beginTransactionOut, endTransactionOut, dataValidOut}}, 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();
    ci_read(3'd5, 9'd0, rd);
    chk("rst_status", rd, 32'd0);
    ci_read(3'd1, 9'd0, rd);
    chk("rst_bus_addr_reg", rd, 32'd0);
    ci_read(3'd0, 9'h1FE, rd);
    chk("rst_mem_kept", rd, wdat[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ram_dma_ci_burst.md
Name: ram_dma_ci_burst

Overview:
- Custom-instruction DMA engine with an internal dual-port scratch memory, parametrised in memory depth.
- Moves data in both directions: bus→memory (read) and memory→bus (write).
- Splits a block into bursts automatically; the last burst is shortened when needed.
- Sits on the CPU custom-instruction port and on the shared bus as an arbitrated master.

Parameters:
customId, 8'h00, custom-instruction number this block answers to
MEM_ADDR_WIDTH, 9, scratch memory address width (1..9); depth = 2^MEM_ADDR_WIDTH words of 32 bits
BLOCK_WIDTH, 10, width of the block-size register (total words per transfer)

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  custom-instruction start strobe
valueA  in  32  CI operand A: [31:13] must be 0, [12:10] select, [9] write, [MEM_ADDR_WIDTH-1:0] memory address
valueB  in  32  CI write data
ciN  in  8  CI number
done  out  1  CI completion, 1-cycle pulse
result  out  32  CI read data; 0 whenever done=0
requestTransaction  out  1  bus request to arbiter
transactionGranted  in  1  arbiter grant
addressDataIn  in  32  bus read data (big-endian bytes)
endTransactionIn  in  1  slave end of transaction
dataValidIn  in  1  read beat valid
busErrorIn  in  1  bus error
busy  in  1  slave stall during a write burst
addressDataOut  out  32  address in the begin cycle, data in write beats, otherwise 0
byteEnablesOut  out  4  4'hF in the begin cycle, otherwise 0
burstSizeOut  out  8  beats-1 in the begin cycle, otherwise 0
readNotWriteOut  out  1  1 = read burst, valid in the begin cycle
beginTransactionOut  out  1  1-cycle burst start
endTransactionOut  out  1  1-cycle pulse after the last write beat
dataValidOut  out  1  write beat valid

Behaviour:
- Reset (reset=0): state IDLE; all outputs 0; all registers 0. Memory contents are not cleared. Takes effect mid-burst immediately.
- CI is selected when start=1, ciN==customId and valueA[31:13]==0.
- CI write (valueA[9]=1): done=1 in cycle N+1.
  - sel 0: memory[addr] ← valueB
  - sel 1: bus start address
  - sel 2: memory start address
  - sel 3: block size
  - sel 4: burst size (beats-1)
  - sel 5: control
- CI read (valueA[9]=0): done=1 and result valid in cycle N+2. sel 0..4 read back the values above; sel 5 reads status.
- Undefined selects: a write is ignored; a read returns 0. done is still produced in both cases.
- Control write:
  - 1 starts a read transfer; 2 starts a write transfer; other values are ignored.
  - The control register self-clears the next cycle.
  - A start while status.busy=1 is ignored.
- Status: bit0 busy, bit1 error (sticky), bit2 complete (sticky). A new accepted start clears bits 1 and 2.
- FSM states: IDLE → INIT (load counters) → REQ → BEGIN → XFER → NEXT → (REQ | IDLE); ERRWAIT → IDLE.
  - REQ: requestTransaction=1 until transactionGranted.
  - BEGIN: one cycle; beats = min(remaining, burst_size+1).
  - NEXT: go to REQ if remaining>0, else IDLE and set complete.
- Block size 0: INIT goes straight to IDLE, complete=1, no bus request.
- Read XFER:
  - Each dataValidIn beat writes byte-swapped addressDataIn to memory[memAddr].
  - memAddr increments modulo depth; bus address += 4; remaining -= 1.
  - The burst ends on endTransactionIn.
- Write XFER:
  - Memory is prefetched (1-cycle RAM latency). Data is byte-swapped on output.
  - dataValidOut=1 with stable data while busy=1.
  - A beat is counted when dataValidOut & ~busy.
  - After the last beat: dataValidOut=0 and endTransactionOut=1 for one cycle.
- The next burst address is the last address+4; memAddr continues from where it stopped.
- busErrorIn in XFER:
  - error=1 and the transfer is aborted.
  - If endTransactionIn=1 in the same cycle, go to IDLE; otherwise go to ERRWAIT and wait for endTransactionIn.
  - All bus outputs go to 0 at once; complete stays 0.
- CI memory access is allowed while busy. If the CI and the DMA write the same address in the same cycle, the DMA data is stored.
- Counter widths:
  - remaining: BLOCK_WIDTH bits.
  - beat counter: 9 bits, which holds 256 beats.

Test Plan:
- CI write memory[5]=0xDEADBEEF, then CI read sel0 addr5 → done at N+1 and N+2; result 0xDEADBEEF only in the done cycle.
- Read: bus addr 0x100, mem 0, block 10, burst 3 (4 beats); slave returns 0x11223344 on the first beat → bursts of 4, 4, 2 at 0x100, 0x110, 0x120; burstSizeOut 3, 3, 1; memory[0]=0x44332211; status reaches 0b100.
- Write: mem 0x1FE, block 4, busy high for 2 cycles mid-burst → memory wraps from 0x1FF to 0x000; dataValidOut held stable while busy; exactly 4 beats; endTransactionOut pulse after the last beat.
- busErrorIn with endTransactionIn=0 on beat 2 → ERRWAIT until endTransactionIn, then IDLE; status 0b010; a new start clears the error.
- Block size 0 → no requestTransaction; status 0b100. A second start while busy → ignored.
- reset=0 in the middle of a write burst → all outputs 0 in the same cycle; after release, status reads 0 and memory is preserved.
